// File: rtl/spec_rollback_ctrl_pkg.sv
// Shared types and width helpers for the speculative-branch rollback controller.
package spec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SQUASH   = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  localparam int DEF_NUM_TAG     = 4;
  localparam int DEF_NUM_REG     = 8;
  localparam int DEF_SPEC_DEPTH  = 4;
  localparam int DEF_PC_BIT      = 4;
  localparam int DEF_INST_ID_BIT = 8;
  localparam int DEF_CNT_BIT     = 16;

  // Level 0 means "not speculative", so one extra code beyond the depth is needed.
  function automatic int spec_level_bit(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_SPEC_LEVEL_BIT = spec_level_bit(DEF_SPEC_DEPTH);

  function automatic int remap_lsb(input int level, input int level_bit);
    return level * level_bit;
  endfunction

endpackage

// File: rtl/spec_rollback_ctrl_if.sv
// Speculation-resolve, squash/restore and fetch-redirect signals of the rollback controller.
interface spec_rollback_ctrl_if
  import spec_pkg::*;
#(
  parameter int NUM_TAG        = DEF_NUM_TAG,
  parameter int NUM_REG        = DEF_NUM_REG,
  parameter int SPEC_DEPTH     = DEF_SPEC_DEPTH,
  parameter int PC_BIT         = DEF_PC_BIT,
  parameter int INST_ID_BIT    = DEF_INST_ID_BIT,
  parameter int CNT_BIT        = DEF_CNT_BIT,
  parameter int REG_ID_BIT     = $clog2(NUM_REG),
  parameter int SPEC_LEVEL_BIT = spec_level_bit(SPEC_DEPTH)
);

  logic                                     br_pred_vld;
  logic                                     br_pred_succ;
  logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] br_pred_succ_nxt_levels;
  logic [SPEC_LEVEL_BIT-1:0]                br_pred_fail_level;
  logic [NUM_TAG*REG_ID_BIT-1:0]            br_pred_fail_tag_map;
  logic [PC_BIT-1:0]                        br_pred_fail_pc;
  logic [INST_ID_BIT-1:0]                   br_pred_fail_id;
  logic                                     fu_busy;
  logic                                     redirect_rdy;

  logic                                     busy;
  logic                                     squash_vld;
  logic [SPEC_LEVEL_BIT-1:0]                squash_level;
  logic                                     tag_map_restore_vld;
  logic [NUM_TAG*REG_ID_BIT-1:0]            tag_map_restore;
  logic                                     redirect_vld;
  logic [PC_BIT-1:0]                        redirect_pc;
  logic [INST_ID_BIT-1:0]                   redirect_id;
  logic [CNT_BIT-1:0]                       rollback_cnt;

  modport master (
    output br_pred_vld, br_pred_succ, br_pred_succ_nxt_levels, br_pred_fail_level,
           br_pred_fail_tag_map, br_pred_fail_pc, br_pred_fail_id, fu_busy, redirect_rdy,
    input  busy, squash_vld, squash_level, tag_map_restore_vld, tag_map_restore,
           redirect_vld, redirect_pc, redirect_id, rollback_cnt
  );

  modport slave (
    input  br_pred_vld, br_pred_succ, br_pred_succ_nxt_levels, br_pred_fail_level,
           br_pred_fail_tag_map, br_pred_fail_pc, br_pred_fail_id, fu_busy, redirect_rdy,
    output busy, squash_vld, squash_level, tag_map_restore_vld, tag_map_restore,
           redirect_vld, redirect_pc, redirect_id, rollback_cnt
  );

endinterface

// File: rtl/spec_rollback_ctrl.sv
// Misprediction recovery sequencer: squash + tag-map restore, FU drain, then fetch redirect.
module spec_rollback_ctrl
  import spec_pkg::*;
#(
  parameter int NUM_TAG        = DEF_NUM_TAG,
  parameter int NUM_REG        = DEF_NUM_REG,
  parameter int SPEC_DEPTH     = DEF_SPEC_DEPTH,
  parameter int PC_BIT         = DEF_PC_BIT,
  parameter int INST_ID_BIT    = DEF_INST_ID_BIT,
  parameter int CNT_BIT        = DEF_CNT_BIT,
  parameter int REG_ID_BIT     = $clog2(NUM_REG),
  parameter int SPEC_LEVEL_BIT = spec_level_bit(SPEC_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spec_rollback_ctrl_if.slave  bus
);

  localparam int MAP_W = NUM_TAG * REG_ID_BIT;

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [SPEC_LEVEL_BIT-1:0] r_lvl;
  logic [SPEC_LEVEL_BIT-1:0] w_lvl_nxt;
  logic [SPEC_LEVEL_BIT-1:0] w_remap_lvl;
  logic [SPEC_LEVEL_BIT-1:0] r_squash_level;
  logic [MAP_W-1:0]          r_map;
  logic [PC_BIT-1:0]         r_pc;
  logic [INST_ID_BIT-1:0]    r_id;
  logic [CNT_BIT-1:0]        r_cnt;
  logic                      r_squash_vld;
  logic                      r_redirect_vld;
  logic                      w_fail_now;
  logic                      w_succ_now;
  logic                      w_accept;

  assign w_fail_now = bus.br_pred_vld & ~bus.br_pred_succ;
  assign w_succ_now = bus.br_pred_vld &  bus.br_pred_succ;
  // A fail while recovering only matters if it belongs to an older branch.
  assign w_accept   = w_fail_now & ((r_state == ST_IDLE) | (bus.br_pred_fail_level < r_lvl));

  always_comb begin
    w_remap_lvl = '0;
    for (int k = 0; k <= SPEC_DEPTH; k++) begin
      if (r_lvl == SPEC_LEVEL_BIT'(k)) begin
        w_remap_lvl = bus.br_pred_succ_nxt_levels[remap_lsb(k, SPEC_LEVEL_BIT) +: SPEC_LEVEL_BIT];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lvl_nxt   = r_lvl;
    if (w_accept) begin
      w_state_nxt = ST_SQUASH;
      w_lvl_nxt   = bus.br_pred_fail_level;
    end else begin
      if (w_succ_now && (r_state != ST_IDLE)) begin
        w_lvl_nxt = w_remap_lvl;
      end
      unique case (r_state)
        ST_IDLE:     w_state_nxt = ST_IDLE;
        ST_SQUASH:   w_state_nxt = ST_DRAIN;
        ST_DRAIN:    if (!bus.fu_busy) w_state_nxt = ST_REDIRECT;
        ST_REDIRECT: if (r_redirect_vld && bus.redirect_rdy) w_state_nxt = ST_IDLE;
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_lvl          <= '0;
      r_squash_level <= '0;
      r_map          <= '0;
      r_pc           <= '0;
      r_id           <= '0;
      r_cnt          <= '0;
      r_squash_vld   <= 1'b0;
      r_redirect_vld <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_lvl          <= w_lvl_nxt;
      r_squash_vld   <= (w_state_nxt == ST_SQUASH);
      r_redirect_vld <= (w_state_nxt == ST_REDIRECT);
      if (w_accept) begin
        r_squash_level <= bus.br_pred_fail_level;
        r_map          <= bus.br_pred_fail_tag_map;
        r_pc           <= bus.br_pred_fail_pc;
        r_id           <= bus.br_pred_fail_id;
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_BIT'(1);
      end
    end
  end

  // Issue must stall in the fail cycle itself, before the state register catches up.
  assign bus.busy                = w_fail_now | (r_state != ST_IDLE);
  assign bus.squash_vld          = r_squash_vld;
  assign bus.squash_level        = r_squash_level;
  assign bus.tag_map_restore_vld = r_squash_vld;
  assign bus.tag_map_restore     = r_map;
  assign bus.redirect_vld        = r_redirect_vld;
  assign bus.redirect_pc         = r_pc;
  assign bus.redirect_id         = r_id;
  assign bus.rollback_cnt        = r_cnt;

endmodule
